// File: rtl/mem_io_responder.sv
// mem_io_responder: byte-wide CPU memory responder. Low addresses hit a
// local RAM; the 0x3xxxx window exposes an RX/TX byte link, a cycle
// counter with a latched snapshot, and a sticky program-stop flag.
module mem_io_responder #(
    parameter int RAM_AW  = 17,
    parameter int FIFO_AW = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_addr,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        prog_stop,
    output logic        tx_overflow
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int RAM_N = 1 << RAM_AW;

    // Address decode
    logic              io_sel;
    logic [15:0]       io_off;
    logic [RAM_AW-1:0] ram_idx;
    logic              wr_data, wr_ctl, rd_data, rd_ctl, rd_any;
    logic              unused_addr;

    assign io_sel      = (mem_addr[17:16] == 2'b11);
    assign io_off      = mem_addr[15:0];
    assign ram_idx     = mem_addr[RAM_AW-1:0];
    assign wr_data     = io_sel &&  mem_wr && (io_off == 16'h0000);
    assign wr_ctl      = io_sel &&  mem_wr && (io_off == 16'h0004);
    assign rd_data     = io_sel && !mem_wr && (io_off == 16'h0000);
    assign rd_ctl      = io_sel && !mem_wr && (io_off == 16'h0004);
    assign rd_any      = !mem_wr;
    assign unused_addr = ^mem_addr[31:18];

    // RAM (not reset) and its registered read port
    logic [7:0] ram_q [0:RAM_N-1];
    logic [7:0] ram_rd_q;

    // Write-first not needed: a cycle is either a write or a read
    always_ff @(posedge clk_in) begin
        if (!io_sel && mem_wr)
            ram_q[ram_idx] <= mem_dout;
        if (!io_sel && !mem_wr)
            ram_rd_q <= ram_q[ram_idx];
    end

    // RX FIFO
    logic [7:0]     rx_mem_q [0:DEPTH-1];
    logic [FIFO_AW:0] rx_wp_q, rx_rp_q;
    logic           rx_empty, rx_full, rx_push, rx_pop;
    logic           rdy_q, rd_data_prev_q;

    assign rx_empty = (rx_wp_q == rx_rp_q);
    assign rx_full  = (rx_wp_q[FIFO_AW] != rx_rp_q[FIFO_AW]) &&
                      (rx_wp_q[FIFO_AW-1:0] == rx_rp_q[FIFO_AW-1:0]);
    assign rx_ready = rdy_q && !rx_full;
    assign rx_push  = rx_valid && rx_ready;
    // A held read of the data port consumes only one byte
    assign rx_pop   = rd_data && !rd_data_prev_q && !rx_empty;

    // RX storage write
    always_ff @(posedge clk_in) begin
        if (rx_push)
            rx_mem_q[rx_wp_q[FIFO_AW-1:0]] <= rx_data;
    end

    // RX pointers, ready enable and previous-read tracker
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rx_wp_q        <= '0;
            rx_rp_q        <= '0;
            rdy_q          <= 1'b0;
            rd_data_prev_q <= 1'b0;
        end else begin
            rdy_q          <= 1'b1;
            rd_data_prev_q <= rd_data;
            if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
            if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
        end
    end

    // TX FIFO
    logic [7:0]       tx_mem_q [0:DEPTH-1];
    logic [FIFO_AW:0] tx_wp_q, tx_rp_q;
    logic             tx_empty, tx_full, tx_req, tx_push, tx_pop;
    logic [7:0]       tx_wdata;
    logic             prog_stop_q, tx_ovf_q;

    assign tx_empty    = (tx_wp_q == tx_rp_q);
    assign tx_full     = (tx_wp_q[FIFO_AW] != tx_rp_q[FIFO_AW]) &&
                         (tx_wp_q[FIFO_AW-1:0] == tx_rp_q[FIFO_AW-1:0]);
    assign tx_valid    = !tx_empty;
    assign tx_data     = tx_mem_q[tx_rp_q[FIFO_AW-1:0]];
    assign tx_req      = (wr_data && (mem_dout != 8'h00)) || wr_ctl;
    assign tx_wdata    = wr_ctl ? 8'h00 : mem_dout;
    // Full is judged before this cycle's pop, so a same-cycle pop never makes room
    assign tx_push     = tx_req && !tx_full;
    assign tx_pop      = tx_valid && tx_ready;
    assign prog_stop   = prog_stop_q;
    assign tx_overflow = tx_ovf_q;

    // TX storage write
    always_ff @(posedge clk_in) begin
        if (tx_push)
            tx_mem_q[tx_wp_q[FIFO_AW-1:0]] <= tx_wdata;
    end

    // TX pointers and sticky status flags
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            tx_wp_q     <= '0;
            tx_rp_q     <= '0;
            prog_stop_q <= 1'b0;
            tx_ovf_q    <= 1'b0;
        end else begin
            if (tx_push)           tx_wp_q     <= tx_wp_q + 1'b1;
            if (tx_pop)            tx_rp_q     <= tx_rp_q + 1'b1;
            if (wr_ctl)            prog_stop_q <= 1'b1;
            if (tx_req && tx_full) tx_ovf_q    <= 1'b1;
        end
    end

    // Cycle counter and snapshot
    logic [31:0] cnt_q, snap_q;

    // Free-running counter; snapshot taken by a read of the low byte
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cnt_q  <= '0;
            snap_q <= '0;
        end else begin
            cnt_q <= cnt_q + 32'd1;
            if (rd_ctl) snap_q <= cnt_q;
        end
    end

    // IO read data
    logic [7:0] io_rd_d, io_rd_q;
    logic       rd_ram_q;

    // Select the byte an IO read returns
    always_comb begin
        io_rd_d = 8'h00;
        case (io_off)
            16'h0000: io_rd_d = rx_empty ? 8'h00 : rx_mem_q[rx_rp_q[FIFO_AW-1:0]];
            16'h0004: io_rd_d = cnt_q[7:0];
            16'h0005: io_rd_d = snap_q[15:8];
            16'h0006: io_rd_d = snap_q[23:16];
            16'h0007: io_rd_d = snap_q[31:24];
            default:  io_rd_d = 8'h00;
        endcase
    end

    // Read-response source tracking; writes leave mem_din unchanged
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            io_rd_q  <= 8'h00;
            rd_ram_q <= 1'b0;
        end else if (rd_any) begin
            rd_ram_q <= !io_sel;
            if (io_sel) io_rd_q <= io_rd_d;
        end
    end

    assign mem_din = rd_ram_q ? ram_rd_q : io_rd_q;

endmodule

// File: doc/mem_io_responder.md
MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

Parameters
REQ-001 The block SHALL provide parameter RAM_AW, default 17, meaning RAM byte-address width (2^RAM_AW bytes).
REQ-002 The block SHALL provide parameter FIFO_AW, default 4, meaning log2 depth of the RX FIFO and the TX FIFO.

Interface
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk_in  input  1  clock; all state updates on the rising edge.
REQ-005 rst_in  input  1  asynchronous active-low reset.
REQ-006 mem_addr  input  32  byte address driven by the CPU.
REQ-007 mem_wr  input  1  1 = write cycle, 0 = read cycle.
REQ-008 mem_dout  input  8  CPU write data.
REQ-009 mem_din  output  8  read data returned to the CPU.
REQ-010 rx_data  input  8  inbound byte from the host link.
REQ-011 rx_valid  input  1  rx_data valid.
REQ-012 rx_ready  output  1  RX FIFO not full.
REQ-013 tx_data  output  8  outbound byte, head of the TX FIFO.
REQ-014 tx_valid  output  1  TX FIFO not empty.
REQ-015 tx_ready  input  1  host link accepts tx_data.
REQ-016 prog_stop  output  1  sticky program-stop flag.
REQ-017 tx_overflow  output  1  sticky flag: a TX push was dropped.

Function
REQ-018 Decode: IO space when mem_addr[17:16]==2'b11; otherwise RAM at index mem_addr[RAM_AW-1:0].
REQ-019 RAM write: mem_wr=1 stores mem_dout at the rising edge of the same cycle; no response.
REQ-020 RAM read: mem_wr=0 registers RAM[addr] into mem_din at the edge ending the address cycle, giving 1-cycle latency (data valid in the following cycle).
REQ-021 Write to 0x30000 with mem_dout!=0x00 pushes mem_dout into the TX FIFO; mem_dout==0x00 is ignored.
REQ-022 Write to 0x30004 sets prog_stop=1 and pushes 0x00 into the TX FIFO.
REQ-023 TX push while the TX FIFO is full is dropped and sets tx_overflow=1; a simultaneous pop frees no space for that push.
REQ-024 TX pop occurs when tx_valid && tx_ready; tx_data is the head entry, first-word-fall-through.
REQ-025 RX push occurs when rx_valid && rx_ready; rx_ready = !rx_full.
REQ-026 Read of 0x30000 returns the RX head in mem_din, or 0x00 if the RX FIFO is empty.
REQ-027 A read of 0x30000 pops the RX FIFO only on the first cycle of the access: no pop if the previous cycle was also a read of 0x30000.
REQ-028 A pop on an empty RX FIFO is a no-op; a push and pop in the same cycle on a non-empty, non-full RX FIFO leaves the count unchanged.
REQ-029 cycle_cnt is a 32-bit counter that increments every cycle after reset release and wraps from 0xFFFFFFFF to 0.
REQ-030 Read of 0x30004 returns cycle_cnt[7:0] and latches cycle_cnt into a snapshot register in the same edge.
REQ-031 Reads of 0x30005, 0x30006 and 0x30007 return snapshot bytes [15:8], [23:16] and [31:24] respectively.
REQ-032 Reads of any other IO address return 0x00; writes to any other IO address are ignored.
REQ-033 FIFO pointers are FIFO_AW+1 bits; full/empty are derived from pointer MSB and equality, with wrap-around.

Reset
REQ-034 While rst_in=0, mem_din=0x00, tx_valid=0, rx_ready=0, prog_stop=0, tx_overflow=0, cycle_cnt=0, snapshot=0, both FIFOs empty, and the previous-read tracker is cleared.
REQ-035 Reset asserted mid-operation discards all FIFO contents immediately; RAM contents are not reset.
REQ-036 rx_ready rises to 1 in the first cycle after reset release.

Verification
REQ-037 Write 0xA5 to 0x00100, then read 0x00100 -> mem_din=0xA5 one cycle after the read address.
REQ-038 Writes of 0x48, 0x00 and 0x49 to 0x30000 with tx_ready=1 -> tx_data sequence is 0x48, 0x49 only; tx_overflow=0.
REQ-039 Push 16 RX bytes 0x01..0x10, assert rx_valid for a 17th byte -> rx_ready=0; eight single-cycle reads of 0x30000 return 0x01..0x08; a 3-cycle held read of 0x30000 pops once.
REQ-040 Read 0x30004 at cycle_cnt=0x12345678, then read 0x30005..0x30007 -> bytes returned are 0x78, 0x56, 0x34, 0x12, despite the counter advancing.
REQ-041 With tx_ready=0, perform 17 writes of 0x41 to 0x30000 -> 16 entries held, tx_overflow=1; then write 0x30004 -> prog_stop=1.
REQ-042 Pull rst_in low with both FIFOs half full -> tx_valid=0 and mem_din=0x00 immediately; data written to RAM before reset reads back after reset release.
